// File: rtl/ttt_sweep_scheduler_pkg.sv
// ttt_pkg: shared types for the sweep scheduler and its event FIFO.
//   instr_t       - core instruction encoding (6-7 reserved)
//   sched_state_t - scheduler FSM state, also exported on dbg_state
//   event_t       - one FIFO entry: neuron id plus start/stop bits
//   is_prog_instr - true for the four host-programming instructions
package ttt_pkg;

  // Widest neuron id an event can carry; the top uses the low ID_W bits.
  localparam int EVT_ID_W = 8;

  typedef enum logic [2:0] {
    INSTR_NOP         = 3'd0,
    INSTR_TICK        = 3'd1,
    INSTR_PROG_THRESH = 3'd2,
    INSTR_PROG_DUR    = 3'd3,
    INSTR_PROG_GOOD   = 3'd4,
    INSTR_PROG_BAD    = 3'd5
  } instr_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2,
    ST_PROG  = 2'd3
  } sched_state_t;

  typedef struct packed {
    logic [EVT_ID_W-1:0] id;
    logic [1:0]          kind;
  } event_t;

  function automatic logic is_prog_instr(input logic [2:0] instr);
    return (instr >= INSTR_PROG_THRESH) && (instr <= INSTR_PROG_BAD);
  endfunction

endpackage

// File: rtl/ttt_sweep_scheduler_event_fifo.sv
// ttt_event_fifo: synchronous FIFO of event_t built as a shift register so
// the head entry is always a flop (entry 0) and stays stable while stalled.
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_push, i_data  write one event (ignored when full and not popping)
//   o_valid         FIFO non-empty
//   i_ready         pop the head when o_valid && i_ready
//   o_head          head event
//   o_count         number of stored events (0..DEPTH)
module ttt_event_fifo
  import ttt_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  event_t        i_data,
  output logic          o_valid,
  input  logic          i_ready,
  output event_t        o_head,
  output logic [CW-1:0] o_count
);

  event_t          r_mem [DEPTH];
  logic [CW-1:0]   r_count;
  logic            w_pop;
  logic            w_full;
  logic            w_push;
  logic [AW-1:0]   w_wr_idx;

  assign w_pop  = (r_count != '0) && i_ready;
  assign w_full = (r_count == CW'(DEPTH));
  assign w_push = i_push && (!w_full || w_pop);
  // When popping in the same cycle every entry moves down one, so the new
  // entry lands one slot lower. Modulo arithmetic covers the full case.
  assign w_wr_idx = w_pop ? (r_count[AW-1:0] - 1'b1) : r_count[AW-1:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_pop) begin
        for (int i = 0; i < DEPTH - 1; i++) r_mem[i] <= r_mem[i+1];
      end
      if (w_push) r_mem[w_wr_idx] <= i_data;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_valid = (r_count != '0);
  assign o_head  = r_mem[0];
  assign o_count = r_count;

endmodule

// File: rtl/ttt_sweep_scheduler.sv
// ttt_sweep_scheduler: time-multiplexes the shared core over all neurons.
// A tick starts a sweep issuing INSTR_TICK for ids 0..N-1; non-zero core
// results are queued as events. In IDLE, host writes are forwarded to the core.
//   clock_fast, reset                  clock, async active-low reset
//   tick                               start-sweep strobe (overrun if busy)
//   prog_valid/prog_ready              host write handshake; a transfer
//                                      happens on a rising edge where both
//                                      are 1; the host holds its fields until
//   prog_instr/prog_id/prog_word       write contents
//   prog_err                           rejected write pulse
//   core_neuron_id/instruction/prog_data  registered drive to the core
//   core_startstop                     core result (bit0 start, bit1 stop)
//   evt_valid/evt_ready/evt_id/evt_kind   event stream out
//   busy, sweep_done, overrun          status
//   dbg_state                          current FSM state
module ttt_sweep_scheduler
  import ttt_pkg::*;
#(
  parameter int  NUM_PROCESSORS = 10,
  parameter int  PROG_WIDTH     = 8,
  parameter int  CORE_LATENCY   = 1,
  parameter int  EVT_DEPTH      = 4,
  localparam int ID_W           = (NUM_PROCESSORS > 1) ? $clog2(NUM_PROCESSORS) : 1,
  localparam int CNT_W          = $clog2(EVT_DEPTH) + 1
) (
  input  logic                  clock_fast,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  prog_valid,
  output logic                  prog_ready,
  input  logic [2:0]            prog_instr,
  input  logic [ID_W-1:0]       prog_id,
  input  logic [PROG_WIDTH-1:0] prog_word,
  output logic                  prog_err,
  output logic [ID_W-1:0]       core_neuron_id,
  output logic [2:0]            core_instruction,
  output logic [PROG_WIDTH-1:0] core_prog_data,
  input  logic [1:0]            core_startstop,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [ID_W-1:0]       evt_id,
  output logic [1:0]            evt_kind,
  output logic                  busy,
  output logic                  sweep_done,
  output logic                  overrun,
  output sched_state_t          dbg_state
);

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_PROCESSORS - 1);
  localparam logic [ID_W:0]   NUM_IDS = (ID_W + 1)'(NUM_PROCESSORS);

  sched_state_t            r_state;
  logic [ID_W-1:0]         r_k;
  logic [CORE_LATENCY-1:0] r_pipe_v;
  logic [ID_W-1:0]         r_pipe_id [CORE_LATENCY];
  logic                    r_prog_err;
  logic                    r_sweep_done;
  logic                    r_overrun;

  logic                    w_issue;
  logic                    w_prog_fire;
  logic                    w_prog_ok;
  logic                    w_drained;
  logic                    w_push;
  logic [CORE_LATENCY-1:0] w_pipe_shift;
  logic [CNT_W-1:0]        w_fifo_count;
  int                      w_free;
  event_t                  w_push_evt;
  event_t                  w_head;

  // Free slots exclude results still travelling down the pipeline, and a
  // sweep only issues with more than CORE_LATENCY of them left, so a push
  // can never meet a full FIFO.
  always_comb begin
    w_free  = EVT_DEPTH - int'(w_fifo_count) - $countones(r_pipe_v);
    w_issue = (r_state == ST_SWEEP) && (w_free > CORE_LATENCY);
  end

  assign prog_ready  = (r_state == ST_IDLE) && !tick;
  assign w_prog_fire = prog_valid && prog_ready;
  assign w_prog_ok   = ({1'b0, prog_id} < NUM_IDS) && is_prog_instr(prog_instr);

  // CORE_LATENCY counts from the edge that presents an id to the core; the
  // last pipeline stage lines up with that id's core_startstop.
  assign w_push     = r_pipe_v[CORE_LATENCY-1] && (core_startstop != 2'b00);
  assign w_push_evt = '{id: EVT_ID_W'(r_pipe_id[CORE_LATENCY-1]), kind: core_startstop};

  // Drained once nothing is left in the pipeline after this edge (the last
  // stage is consumed by the push this cycle).
  assign w_pipe_shift = r_pipe_v << 1;
  assign w_drained    = (w_pipe_shift == '0);

  always_ff @(posedge clock_fast or negedge reset) begin
    if (!reset) begin
      r_pipe_v <= '0;
      for (int i = 0; i < CORE_LATENCY; i++) r_pipe_id[i] <= '0;
    end else begin
      r_pipe_v[0]  <= w_issue;
      r_pipe_id[0] <= r_k;
      for (int i = 1; i < CORE_LATENCY; i++) begin
        r_pipe_v[i]  <= r_pipe_v[i-1];
        r_pipe_id[i] <= r_pipe_id[i-1];
      end
    end
  end

  always_ff @(posedge clock_fast or negedge reset) begin
    if (!reset) begin
      r_state          <= ST_IDLE;
      r_k              <= '0;
      core_neuron_id   <= '0;
      core_instruction <= INSTR_NOP;
      core_prog_data   <= '0;
      r_prog_err       <= 1'b0;
      r_sweep_done     <= 1'b0;
      r_overrun        <= 1'b0;
    end else begin
      core_instruction <= INSTR_NOP;
      r_prog_err       <= 1'b0;
      r_sweep_done     <= 1'b0;
      if (tick && (r_state != ST_IDLE)) r_overrun <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (tick) begin
            r_state <= ST_SWEEP;
            r_k     <= '0;
          end else if (w_prog_fire) begin
            r_state          <= ST_PROG;
            core_neuron_id   <= prog_id;
            core_prog_data   <= prog_word;
            core_instruction <= w_prog_ok ? prog_instr : INSTR_NOP;
            r_prog_err       <= !w_prog_ok;
          end
        end
        ST_SWEEP: begin
          if (w_issue) begin
            core_neuron_id   <= r_k;
            core_instruction <= INSTR_TICK;
            if (r_k == LAST_ID) r_state <= ST_DRAIN;
            else                r_k     <= r_k + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (w_drained) begin
            r_state      <= ST_IDLE;
            r_sweep_done <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  ttt_event_fifo #(.DEPTH(EVT_DEPTH)) u_fifo (
    .i_clk   (clock_fast),
    .i_rst_n (reset),
    .i_push  (w_push),
    .i_data  (w_push_evt),
    .o_valid (evt_valid),
    .i_ready (evt_ready),
    .o_head  (w_head),
    .o_count (w_fifo_count)
  );

  generate
    if (ID_W < EVT_ID_W) begin : g_id_hi
      logic w_unused_id_hi;
      assign w_unused_id_hi = ^w_head.id[EVT_ID_W-1:ID_W];
    end
  endgenerate

  assign evt_id     = w_head.id[ID_W-1:0];
  assign evt_kind   = w_head.kind;
  assign busy       = (r_state != ST_IDLE);
  assign sweep_done = r_sweep_done;
  assign overrun    = r_overrun;
  assign prog_err   = r_prog_err;
  assign dbg_state  = r_state;

endmodule
